// File: rtl/rx_frame_parser.sv
`default_nettype none
// rx_frame_parser: frames protocol-1 blocks (3 sync, C0..C4, N x 8-byte samples) from the
// receive byte stream and emits command words, TX I/Q + audio samples and sync status.
module rx_frame_parser #(
  parameter logic [7:0] SYNC_BYTE         = 8'h7F,
  parameter int         SAMPLES_PER_BLOCK = 63
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        run,
  input  logic [7:0]  rx_data,
  input  logic        rx_enable,
  output logic [6:0]  cmd_addr,
  output logic        cmd_mox,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  output logic [31:0] tx_iq,
  output logic [31:0] tx_lr,
  output logic        sample_valid,
  output logic        in_sync,
  output logic [7:0]  sync_err
);

  localparam logic [8:0] LAST_CMD  = 9'd4;
  localparam logic [8:0] LAST_DATA = 9'(SAMPLES_PER_BLOCK * 8 - 1);

  typedef enum logic [2:0] {HUNT, S1, S2, CMD, DATA, CHK} state_t;

  state_t      state, state_next;
  logic [8:0]  byte_cnt;
  logic [31:0] cmd_shadow;
  logic [55:0] smp_shadow;
  logic        is_sync;
  logic        cnt_clr, cnt_inc, go_sync, sync_miss, cmd_load, smp_load;

  assign is_sync = (rx_data == SYNC_BYTE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    go_sync    = 1'b0;
    sync_miss  = 1'b0;
    cmd_load   = 1'b0;
    smp_load   = 1'b0;
    if (!run) begin
      state_next = HUNT;
    end else if (rx_enable) begin
      case (state)
        HUNT: if (is_sync) state_next = S1;
        S1: begin
          if (is_sync) state_next = S2;
          else begin
            state_next = HUNT;
            sync_miss  = 1'b1;
          end
        end
        S2: begin
          if (is_sync) begin
            state_next = CMD;
            cnt_clr    = 1'b1;
            go_sync    = 1'b1;
          end else begin
            state_next = HUNT;
            sync_miss  = 1'b1;
          end
        end
        CMD: begin
          if (byte_cnt == LAST_CMD) begin
            state_next = DATA;
            cnt_clr    = 1'b1;
            cmd_load   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DATA: begin
          smp_load = (byte_cnt[2:0] == 3'd7);
          if (byte_cnt == LAST_DATA) begin
            state_next = CHK;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        CHK: begin
          if (is_sync) state_next = S1;
          else begin
            state_next = HUNT;
            sync_miss  = 1'b1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt     <= '0;
      cmd_shadow   <= '0;
      smp_shadow   <= '0;
      cmd_addr     <= '0;
      cmd_mox      <= 1'b0;
      cmd_data     <= '0;
      cmd_valid    <= 1'b0;
      tx_iq        <= '0;
      tx_lr        <= '0;
      sample_valid <= 1'b0;
      in_sync      <= 1'b0;
      sync_err     <= '0;
    end else begin
      cmd_valid    <= 1'b0;
      sample_valid <= 1'b0;

      if (cnt_clr)      byte_cnt <= '0;
      else if (cnt_inc) byte_cnt <= byte_cnt + 9'd1;

      // Shadows only shift; a run drop simply restarts framing so stale bytes are never used.
      if (run && rx_enable) begin
        if (state == CMD)  cmd_shadow <= {cmd_shadow[23:0], rx_data};
        if (state == DATA) smp_shadow <= {smp_shadow[47:0], rx_data};
      end

      if (cmd_load) begin
        cmd_addr  <= cmd_shadow[31:25];
        cmd_mox   <= cmd_shadow[24];
        cmd_data  <= {cmd_shadow[23:0], rx_data};
        cmd_valid <= 1'b1;
      end

      if (smp_load) begin
        tx_lr        <= smp_shadow[55:24];
        tx_iq        <= {smp_shadow[23:0], rx_data};
        sample_valid <= 1'b1;
      end

      if (!run) begin
        in_sync <= 1'b0;
      end else if (go_sync) begin
        in_sync <= 1'b1;
      end else if (sync_miss && in_sync) begin
        in_sync <= 1'b0;
        if (sync_err != 8'hFF) sync_err <= sync_err + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
